led_pattern_gen: RTL

Parametrised LED pattern generator driving an N-wide LED bank from the board clock. A programmable prescaler sets the step rate. A 2-bit mode selects rotate-left, rotate-right, bounce or blink. Supports pause and single-step for bring-up. It is the successor to the fixed 4-LED rotator and sits at the top level next to the board I/O.

---
 rtl/led_pkg.sv | 13 +
 rtl/led_prescaler.sv | 26 ++
 rtl/led_pattern_gen.sv | 87 ++++++++
 3 files changed

// File: rtl/led_pkg.sv
// led_pkg: mode and bounce-direction encodings shared by the LED pattern generator.
package led_pkg;
   typedef enum logic [1:0] {
      MODE_ROT_L  = 2'b00,
      MODE_ROT_R  = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_BLINK  = 2'b11
   } mode_e;
   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;
endpackage

// File: rtl/led_prescaler.sv
// led_prescaler: step-rate counter; adv fires once per DIV+1 cycles when free-running,
// or follows STEP while paused.
module led_prescaler #(
   parameter int DIV_WIDTH = 25
) (
   input  logic                 CLOCK_48,
   input  logic                 RESET,
   input  logic                 ENABLE,
   input  logic                 STEP,
   input  logic [DIV_WIDTH-1:0] DIV,
   input  logic                 clear,
   output logic                 adv
);
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic                 term;
   // >= rather than == so a DIV shrink below the current count never wraps
   always_comb begin
      term  = cnt_q >= DIV;
      adv   = ENABLE ? term : STEP;
      cnt_d = clear ? '0 : !ENABLE ? cnt_q : term ? '0 : cnt_q + 1'b1;
   end
   always_ff @(posedge CLOCK_48) begin
      if (RESET) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: rotate/bounce/blink LED pattern generator with pause and single-step.
// Define LED_ACTIVE_LOW_EN to drive the LED port inverted for active-low boards.
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int N_LEDS    = 4,
   parameter int DIV_WIDTH = 25,
   parameter int RESET_DIV = 24000000
) (
   input  logic                 CLOCK_48,
   input  logic                 RESET,
   input  logic                 ENABLE,
   input  logic                 STEP,
   input  logic [1:0]           MODE,
   input  logic [DIV_WIDTH-1:0] DIV,
   output logic [N_LEDS-1:0]    LED,
   output logic                 TICK
);
   if (N_LEDS < 1 || RESET_DIV < 0) begin : g_bad_params
      $error("led_pattern_gen: invalid parameters");
   end
   function automatic logic [N_LEDS-1:0] init_pat(input logic [1:0] m);
      return (m == MODE_BLINK) ? {N_LEDS{1'b0}} : N_LEDS'(1);
   endfunction
   function automatic logic [N_LEDS-1:0] rot_l(input logic [N_LEDS-1:0] p);
      for (int i = 0; i < N_LEDS; i++) rot_l[i] = p[(i + N_LEDS - 1) % N_LEDS];
   endfunction
   function automatic logic [N_LEDS-1:0] rot_r(input logic [N_LEDS-1:0] p);
      for (int i = 0; i < N_LEDS; i++) rot_r[i] = p[(i + 1) % N_LEDS];
   endfunction
   logic [N_LEDS-1:0] pat_q, pat_d, bounce, step_pat;
   dir_e              dir_q, dir_d, dir_step;
   mode_e             mode_q, mode_d;
   logic              tick_q, tick_d, mode_chg, adv;
   assign mode_chg = mode_e'(MODE) != mode_q;
   led_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_prescaler (
      .CLOCK_48 (CLOCK_48),
      .RESET    (RESET),
      .ENABLE   (ENABLE),
      .STEP     (STEP),
      .DIV      (DIV),
      .clear    (mode_chg),
      .adv      (adv)
   );
   // a single LED has nowhere to bounce to, so it holds
   always_comb begin
      bounce   = (N_LEDS == 1) ? pat_q : (dir_q == DIR_UP) ? pat_q << 1 : pat_q >> 1;
      step_pat = (mode_q == MODE_ROT_L)  ? rot_l(pat_q) :
                 (mode_q == MODE_ROT_R)  ? rot_r(pat_q) :
                 (mode_q == MODE_BOUNCE) ? bounce : ~pat_q;
      dir_step = (mode_q != MODE_BOUNCE) ? dir_q :
                 (dir_q == DIR_UP) ? (bounce[N_LEDS-1] ? DIR_DOWN : DIR_UP) :
                                     (bounce[0] ? DIR_UP : DIR_DOWN);
      pat_d    = pat_q;
      dir_d    = dir_q;
      mode_d   = mode_q;
      tick_d   = 1'b0;
      if (mode_chg) begin
         pat_d  = init_pat(MODE);
         dir_d  = DIR_UP;
         mode_d = mode_e'(MODE);
      end else if (adv) begin
         pat_d  = step_pat;
         dir_d  = dir_step;
         tick_d = 1'b1;
      end
   end
   always_ff @(posedge CLOCK_48) begin
      if (RESET) begin
         pat_q  <= init_pat(MODE);
         dir_q  <= DIR_UP;
         mode_q <= mode_e'(MODE);
         tick_q <= 1'b0;
      end else begin
         pat_q  <= pat_d;
         dir_q  <= dir_d;
         mode_q <= mode_d;
         tick_q <= tick_d;
      end
   end
`ifdef LED_ACTIVE_LOW_EN
   assign LED = ~pat_q;
`else
   assign LED = pat_q;
`endif
   assign TICK = tick_q;
endmodule
